// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : multi-cycle unsigned restoring divider, one quotient bit/clock
// Rev 1.0
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam logic [1:0]    c_st_idle  = 2'd0;
   localparam logic [1:0]    c_st_busy  = 2'd1;
   localparam logic [1:0]    c_st_done  = 2'd2;
   localparam logic [1:0]    c_st_dzero = 2'd3;
   localparam logic [CW-1:0] c_last     = CW'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH:0]   w_trial;
   logic [WIDTH+1:0] w_sum;
   logic             w_no_borrow;
   logic             w_accept;

   // Trial subtraction T - D as T + ~D + 1, one bit wider than T so the
   // carry out of the top bit is the inverted borrow.
   assign w_trial = {r_q, q_q[WIDTH-1]};
   assign w_sum   = {1'b0, w_trial} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};

   // When T >= D the difference is below D, so bit WIDTH of it is always clear.
   assign w_no_borrow = w_sum[WIDTH+1] & ~w_sum[WIDTH];

   assign w_accept = start && ((state_q == c_st_idle) || (state_q == c_st_done));

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      d_d         = d_q;
      r_d         = r_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;

      case (state_q)
         c_st_idle, c_st_done: begin
            if (w_accept) begin
               q_d     = dividend;
               d_d     = divisor;
               r_d     = '0;
               count_d = '0;
               state_d = (divisor == '0) ? c_st_dzero : c_st_busy;
            end
         end

         c_st_busy: begin
            if (count_q == c_last) begin
               state_d     = c_st_done;
               quotient_d  = q_q;
               remainder_d = r_q;
               div_zero_d  = 1'b0;
               done_d      = 1'b1;
            end else begin
               q_d     = {q_q[WIDTH-2:0], w_no_borrow};
               r_d     = w_no_borrow ? w_sum[WIDTH-1:0] : w_trial[WIDTH-1:0];
               count_d = count_q + CW'(1);
            end
         end

         c_st_dzero: begin
            state_d     = c_st_done;
            quotient_d  = '1;
            remainder_d = q_q;
            div_zero_d  = 1'b1;
            done_d      = 1'b1;
         end

         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= c_st_idle;
         q_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         d_q         <= d_d;
         r_q         <= r_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign busy      = (state_q == c_st_busy);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : directed plus random checks of seq_divider against / and %
// Rev 1.0
// ============================================================================
module tb_seq_divider;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_r;
   logic             prev_z;

   seq_divider #(.WIDTH(WIDTH), .CW(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer operands with start high across one edge.
   task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      if (!hold) start = 1'b0;
   endtask

   // Walk cycles after acceptance until done; inj > 0 pulses a stray start then.
   task automatic wait_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int inj);
      int  n;
      bit  got;
      int  exp_lat;
      logic [WIDTH-1:0] exp_q;
      logic [WIDTH-1:0] exp_r;
      exp_lat = (b == 0) ? 1 : WIDTH + 1;
      exp_q   = (b == 0) ? {WIDTH{1'b1}} : a / b;
      exp_r   = (b == 0) ? a : a % b;
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         n++;
         if (inj > 0 && n == inj) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd5;
         end else if (inj > 0 && n == inj + 1) begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            got = 1'b1;
         end else begin
            check("busy_run", 64'(busy), 64'(b != 0));
            check("q_held", 64'(quotient), 64'(prev_q));
            check("r_held", 64'(remainder), 64'(prev_r));
            check("z_held", 64'(div_zero), 64'(prev_z));
         end
      end
      check("latency", 64'(n), 64'(exp_lat));
      check("busy_at_done", 64'(busy), 64'd0);
      check("quotient", 64'(quotient), 64'(exp_q));
      check("remainder", 64'(remainder), 64'(exp_r));
      check("div_zero", 64'(div_zero), 64'(b == 0));
      prev_q = exp_q;
      prev_r = exp_r;
      prev_z = (b == 0);
   endtask

   task automatic after_done(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         check("done_low", 64'(done), 64'd0);
         check("idle_busy", 64'(busy), 64'd0);
         check("q_keep", 64'(quotient), 64'(prev_q));
         check("r_keep", 64'(remainder), 64'(prev_r));
         check("z_keep", 64'(div_zero), 64'(prev_z));
      end
   endtask

   task automatic div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      launch(a, b, 1'b0);
      wait_done(a, b, 0);
      after_done(1);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int               sel;

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      prev_q   = '0;
      prev_r   = '0;
      prev_z   = 1'b0;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_q", 64'(quotient), 64'd0);
      check("rst_r", 64'(remainder), 64'd0);
      check("rst_z", 64'(div_zero), 64'd0);
      reset = 1'b0;
      tick();

      div(32'd100, 32'd7);
      div(32'd5, 32'd9);
      div(32'hFFFF_FFFF, 32'd1);
      div(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      div(32'd3628800, 32'd10);
      div(32'd0, 32'd13);
      div(32'd1234, 32'd0);
      div(32'd6, 32'd3);

      // Stray start during BUSY must neither restart nor add a done.
      launch(32'd100, 32'd7, 1'b0);
      wait_done(32'd100, 32'd7, 5);
      after_done(4);

      // Back-to-back: start held through the run, new operands on done.
      launch(32'd720, 32'd6, 1'b1);
      wait_done(32'd720, 32'd6, 0);
      launch(32'd120, 32'd5, 1'b0);
      wait_done(32'd120, 32'd5, 0);
      after_done(1);

      // Reset mid-division at edge k+10.
      launch(32'hDEAD_BEEF, 32'd3, 1'b0);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_q", 64'(quotient), 64'd0);
      check("mid_rst_r", 64'(remainder), 64'd0);
      check("mid_rst_z", 64'(div_zero), 64'd0);
      prev_q = '0;
      prev_r = '0;
      prev_z = 1'b0;
      after_done(3);
      div(32'd81, 32'd9);

      for (int it = 0; it < 40; it++) begin
         ra  = $urandom >> $urandom_range(0, 31);
         sel = $urandom_range(0, 9);
         if (sel == 0)      rb = '0;
         else if (sel == 1) rb = 32'd1;
         else if (sel == 2) rb = (ra == 32'hFFFF_FFFF) ? ra : ra + 32'd1 + ($urandom & 32'hFF);
         else               rb = $urandom >> $urandom_range(0, 31);
         div(ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
